// File: rtl/alu_seq.sv
// Sequential ALU: one operation in flight, single-cycle arithmetic/logic ops,
// shifts performed one bit per cycle, result held in DONE until consumed.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [3:0]       ALU_control,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRA  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_NAND = 4'b1101;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q;
  logic [3:0]       op_q;
  logic             sign_q;

  logic [WIDTH:0]   sum, diff;
  logic             add_ov, sub_ov;
  logic [WIDTH-1:0] alu_res, shift_next;
  logic             alu_cout, alu_ov;
  logic             is_shift, start_shift;
  logic [SHW-1:0]   amt;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign state_dbg = state_q;

  assign amt         = src2[SHW-1:0];
  assign is_shift    = (ALU_control == OP_SLL) || (ALU_control == OP_SRA) ||
                       (ALU_control == OP_SRL);
  assign start_shift = is_shift && (amt != '0);

  always_comb begin
    sum      = {1'b0, src1} + {1'b0, src2};
    diff     = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
    add_ov   = (src1[WIDTH-1] == src2[WIDTH-1]) && (sum[WIDTH-1] != src1[WIDTH-1]);
    sub_ov   = (src1[WIDTH-1] != src2[WIDTH-1]) && (diff[WIDTH-1] != src1[WIDTH-1]);
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ov   = 1'b0;
    case (ALU_control)
      OP_AND:  alu_res = src1 & src2;
      OP_OR:   alu_res = src1 | src2;
      OP_XOR:  alu_res = src1 ^ src2;
      OP_NOR:  alu_res = ~(src1 | src2);
      OP_NAND: alu_res = ~(src1 & src2);
      OP_ADD: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ov   = add_ov;
      end
      OP_SUB: begin
        alu_res  = diff[WIDTH-1:0];
        alu_cout = diff[WIDTH];
        alu_ov   = sub_ov;
      end
      OP_SLT: begin
        alu_res  = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ov};
        alu_cout = diff[WIDTH];
        alu_ov   = sub_ov;
      end
      // A zero-amount shift completes immediately with the operand unchanged.
      OP_SLL, OP_SRA, OP_SRL: alu_res = src1;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    case (op_q)
      OP_SLL:  shift_next = {result[WIDTH-2:0], 1'b0};
      OP_SRA:  shift_next = {sign_q, result[WIDTH-1:1]};
      default: shift_next = {1'b0, result[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = start_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      zero     <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      cnt_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q   <= ALU_control;
            sign_q <= src1[WIDTH-1];
            if (start_shift) begin
              result   <= src1;
              cnt_q    <= amt;
              zero     <= 1'b0;
              cout     <= 1'b0;
              overflow <= 1'b0;
            end else begin
              result   <= alu_res;
              zero     <= (alu_res == '0);
              cout     <= alu_cout;
              overflow <= alu_ov;
            end
          end
        end
        SHIFT: begin
          result <= shift_next;
          zero   <= (shift_next == '0);
          cnt_q  <= cnt_q - SHW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a 32-bit and an 8-bit instance share one clock,
// results flow through an expected queue and every comparison goes through check().
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel8;
  logic        in_valid, out_ready;
  logic [3:0]  op;
  logic [63:0] a, b;

  logic        in_ready32, out_valid32, zero32, cout32, ov32;
  logic [31:0] result32;
  logic [1:0]  state32;
  logic        in_ready8, out_valid8, zero8, cout8, ov8;
  logic [7:0]  result8;
  logic [1:0]  state8;

  logic        o_valid, o_ready, o_zero, o_cout, o_ov;
  logic [63:0] o_res;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel8), .in_ready(in_ready32),
    .src1(a[31:0]), .src2(b[31:0]), .ALU_control(op), .out_valid(out_valid32),
    .out_ready(out_ready & ~sel8), .result(result32), .zero(zero32), .cout(cout32),
    .overflow(ov32), .state_dbg(state32)
  );

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel8), .in_ready(in_ready8),
    .src1(a[7:0]), .src2(b[7:0]), .ALU_control(op), .out_valid(out_valid8),
    .out_ready(out_ready & sel8), .result(result8), .zero(zero8), .cout(cout8),
    .overflow(ov8), .state_dbg(state8)
  );

  assign o_valid = sel8 ? out_valid8 : out_valid32;
  assign o_ready = sel8 ? in_ready8  : in_ready32;
  assign o_zero  = sel8 ? zero8      : zero32;
  assign o_cout  = sel8 ? cout8      : cout32;
  assign o_ov    = sel8 ? ov8        : ov32;
  assign o_res   = sel8 ? {56'd0, result8} : {32'd0, result32};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation, wait for the result, optionally hold backpressure, consume.
  task automatic do_op(input string nm, input bit s8, input logic [3:0] opc,
                       input logic [63:0] x, input logic [63:0] y,
                       input logic [63:0] er, input logic ez, input logic ec,
                       input logic ev, input int elat, input int hold);
    int          lat;
    bit          busy_ok;
    logic [63:0] exp_res;
    @(negedge clk);
    sel8 = s8; op = opc; a = x; b = y; in_valid = 1'b1;
    exp_q.push_back(er);
    check({nm, ".rdy_pre"}, o_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~x; b = ~y;
    lat = 1; busy_ok = 1'b1;
    while (!o_valid && lat < 100) begin
      if (o_ready !== 1'b0) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    exp_res = exp_q.pop_front();
    check({nm, ".busy"},  busy_ok, 1'b1);
    check({nm, ".valid"}, o_valid, 1'b1);
    check({nm, ".lat"},   lat, elat);
    check({nm, ".res"},   o_res, exp_res);
    check({nm, ".zero"},  o_zero, ez);
    check({nm, ".cout"},  o_cout, ec);
    check({nm, ".ovf"},   o_ov, ev);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({nm, ".hold_valid"}, o_valid, 1'b1);
      check({nm, ".hold_res"},   o_res, exp_res);
      check({nm, ".hold_flags"}, {o_zero, o_cout, o_ov}, {ez, ec, ev});
      check({nm, ".hold_rdy"},   o_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({nm, ".rdy_post"},   o_ready, 1'b1);
    check({nm, ".valid_post"}, o_valid, 1'b0);
  endtask

  initial begin
    bit stray;
    rst_n = 1'b0; sel8 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; a = '0; b = '0;
    #12;
    check("rst.rdy32",   in_ready32, 1'b1);
    check("rst.valid32", out_valid32, 1'b0);
    check("rst.res32",   {32'd0, result32}, 64'd0);
    check("rst.flags32", {zero32, cout32, ov32}, 3'b000);
    check("rst.rdy8",    in_ready8, 1'b1);
    check("rst.valid8",  out_valid8, 1'b0);
    check("rst.res8",    {56'd0, result8}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //     name        8b  op       src1          src2          result        z     c     v     lat hold
    do_op("add_ovf",   0, 4'b0010, 64'h7FFFFFFF, 64'h00000001, 64'h80000000, 1'b0, 1'b0, 1'b1, 1, 0);
    do_op("sub_eq",    0, 4'b0110, 64'h00000005, 64'h00000005, 64'h00000000, 1'b1, 1'b1, 1'b0, 1, 0);
    do_op("slt_neg",   0, 4'b0111, 64'hFFFFFFFF, 64'h00000001, 64'h00000001, 1'b0, 1'b1, 1'b0, 1, 0);
    do_op("sra4",      0, 4'b0101, 64'h80000000, 64'h00000004, 64'hF8000000, 1'b0, 1'b0, 1'b0, 5, 0);
    do_op("and",       0, 4'b0000, 64'hF0F0F0F0, 64'h0FF00FF0, 64'h00F000F0, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("or",        0, 4'b0001, 64'h12340000, 64'h00005678, 64'h12345678, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("xor",       0, 4'b0011, 64'hA5A5A5A5, 64'hA5A5A5A5, 64'h00000000, 1'b1, 1'b0, 1'b0, 1, 0);
    do_op("nor",       0, 4'b1100, 64'h00000000, 64'h00000000, 64'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("nand",      0, 4'b1101, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 1'b1, 1'b0, 1'b0, 1, 0);
    do_op("undef",     0, 4'b1111, 64'h12345678, 64'h9ABCDEF0, 64'h00000000, 1'b1, 1'b0, 1'b0, 1, 0);
    do_op("add_wrap",  0, 4'b0010, 64'hFFFFFFFF, 64'h00000001, 64'h00000000, 1'b1, 1'b1, 1'b0, 1, 0);
    do_op("sub_ovf",   0, 4'b0110, 64'h80000000, 64'h00000001, 64'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1, 0);
    do_op("slt_pos",   0, 4'b0111, 64'h00000001, 64'hFFFFFFFF, 64'h00000000, 1'b1, 1'b0, 1'b0, 1, 0);
    do_op("slt_min",   0, 4'b0111, 64'h80000000, 64'h7FFFFFFF, 64'h00000001, 1'b0, 1'b1, 1'b1, 1, 0);
    do_op("sll31",     0, 4'b0100, 64'h00000001, 64'h0000001F, 64'h80000000, 1'b0, 1'b0, 1'b0, 32, 0);
    do_op("srl31",     0, 4'b1000, 64'h80000000, 64'h0000001F, 64'h00000001, 1'b0, 1'b0, 1'b0, 32, 0);
    do_op("sra_pos",   0, 4'b0101, 64'h40000000, 64'h00000003, 64'h08000000, 1'b0, 1'b0, 1'b0, 4, 0);
    do_op("sll0",      0, 4'b0100, 64'hDEADBEEF, 64'h00000020, 64'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("bp_add",    0, 4'b0010, 64'h00000003, 64'h00000004, 64'h00000007, 1'b0, 1'b0, 1'b0, 1, 3);
    do_op("w8_sll7",   1, 4'b0100, 64'h00000081, 64'h00000007, 64'h00000080, 1'b0, 1'b0, 1'b0, 8, 0);
    do_op("w8_srl0",   1, 4'b1000, 64'h00000081, 64'h00000000, 64'h00000081, 1'b0, 1'b0, 1'b0, 1, 0);
    do_op("w8_add",    1, 4'b0010, 64'h000000FF, 64'h00000001, 64'h00000000, 1'b1, 1'b1, 1'b0, 1, 0);

    // Reset in the middle of a 20-step SLL, then the first op right after release.
    @(negedge clk);
    sel8 = 1'b0; op = 4'b0100; a = 64'h1; b = 64'd20; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    stray = 1'b0;
    repeat (6) begin
      if (out_valid32) stray = 1'b1;
      @(negedge clk);
    end
    check("mid.no_early", stray, 1'b0);
    check("mid.state",    state32, 2'd1);
    rst_n = 1'b0;
    #1;
    check("mid.valid", out_valid32, 1'b0);
    check("mid.res",   {32'd0, result32}, 64'd0);
    check("mid.rdy",   in_ready32, 1'b1);
    check("mid.st",    state32, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op = 4'b0010; a = 64'd2; b = 64'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("first.valid", out_valid32, 1'b1);
    check("first.res",   {32'd0, result32}, 64'd5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    stray = 1'b0;
    repeat (25) begin
      if (out_valid32) stray = 1'b1;
      @(negedge clk);
    end
    check("mid.no_output", stray, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
